lcb_rx_collector: RTL
=====================

// Module: lcb_rx_collector
// PURPOSE
//  N-channel LCB answer collector; successor to the fixed 5-channel commutAdr/ramUART/commRdAdr chain.
//  Each channel buffers one UART answer packet of PKT_BYTES bytes from its uartRx.
//  A round-robin arbiter drains completed packets as one byte stream with channel tag and first/last
//  markers, under a ready/valid handshake, toward the orbit word packers.
//  Sits between the uartRx instances and OrbPacker/SlowPacker in the clk80MHz domain.
// PARAMETERS
//  NCH         5     number of UART channels (1..16)
//  PKT_BYTES   4     bytes per answer packet (2..32)
//  CHW         3     width of channel index, >= clog2(NCH)
//  TIMEOUT_CYC 4000  inter-byte timeout in clk cycles (used only with RX_TIMEOUT_EN)
// PORTS
//  clk       in   1        system clock (clk80MHz)
//  rst       in   1        asynchronous reset, active high
//  iData     in   NCH*8    received bytes, channel c on [8c+7:8c]
//  iValid    in   NCH      1-cycle byte strobe per channel (uartRx oValid)
//  iReady    in   1        downstream accepts current output byte
//  oData     out  8        output byte
//  oChan     out  CHW      channel index of current output byte
//  oValid    out  1        output byte valid
//  oFirst    out  1        current byte is packet byte 0
//  oLast     out  1        current byte is packet byte PKT_BYTES-1
//  oFull     out  NCH      channel holds a complete, undrained packet (READY or DRAIN)
//  oOvf      out  NCH      sticky: byte dropped on channel (cleared only by rst)
//  oTimeout  out  NCH      1-cycle pulse: partial packet discarded (RX_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all outputs 0; every channel in FILL with wrAdr=0; arbiter IDLE; round-robin pointer
//   last=NCH-1, so channel 0 has first priority. Assertion clears immediately (async).
//  Per-channel FSM: FILL -> READY -> DRAIN -> FILL.
//   FILL: on iValid[c], store byte at buf[c][wrAdr] and increment wrAdr.
//    The write at wrAdr=PKT_BYTES-1 moves the channel to READY and clears wrAdr.
//   READY/DRAIN: iValid[c] drops the byte and sets oOvf[c]. This includes the cycle of the final
//    drain handshake; the channel is back in FILL only on the following cycle.
//  Arbiter FSM: IDLE -> SEND -> IDLE.
//   IDLE: scan channels last+1 .. last+NCH, modulo NCH. Select the first READY channel.
//    Set that channel to DRAIN, set last=c, rdAdr=0, and register byte 0 onto the outputs with oValid=1.
//   SEND: a handshake is oValid & iReady.
//    On a handshake with rdAdr<PKT_BYTES-1: increment rdAdr and present the next byte on the next
//     cycle; oValid stays 1.
//    On the handshake at the last byte: deassert oValid, return the channel to FILL, arbiter to IDLE.
//    With iReady=0: oData/oChan/oFirst/oLast are held stable.
//  Latency:
//   Last byte captured at edge E with arbiter idle -> channel READY after E.
//   Arbiter selects it at E+1 -> oValid=1 after E+1.
//   Minimum packet output = PKT_BYTES cycles with iReady tied 1.
//   oValid is low for at least 1 cycle between packets.
//  oFirst = oValid & (rdAdr==0); oLast = oValid & (rdAdr==PKT_BYTES-1). Both are registered with oData.
//  Simultaneous READY channels are served strictly round-robin; no channel waits more than NCH-1 packets.
//  Buffers are register arrays of NCH*PKT_BYTES*8 bits; no RAM macros.
//  Counters are sized clog2(PKT_BYTES); wrap to 0 only via the transitions above, never by overflow.
// CONFIGURATION
//  RX_TIMEOUT_EN defined:
//   Each FILL channel with wrAdr!=0 counts clocks since its last iValid.
//   When the count reaches TIMEOUT_CYC-1 with no iValid that cycle: wrAdr<=0 and oTimeout[c]=1 for one
//    cycle.
//   An iValid in the same cycle wins: the byte is stored and the counter is reset.
//  RX_TIMEOUT_EN undefined: partial packets are held indefinitely; oTimeout tied 0; TIMEOUT_CYC unused.
// TESTING
//  (NCH=5, PKT_BYTES=4, iReady=1)
//  ch2 gets bytes 11,22,33,44 -> oValid 2 cycles after the 4th; oChan=2; bytes 11,22,33,44;
//   oFirst on 11, oLast on 44.
//  ch0 and ch4 complete on the same cycle, last=4 -> ch0 packet first, then ch4 after a 1-cycle gap.
//  iReady=0 for 3 cycles during byte 2 of ch1 -> byte 2 held stable; stream resumes, no byte lost
//   or duplicated.
//  5th byte on ch3 while its packet is READY -> byte dropped, oOvf[3]=1 until rst; next packet intact.
//  rst asserted mid-SEND -> outputs 0 at once; after release all oFull=0 and new packets arrive intact.
//  RX_TIMEOUT_EN, TIMEOUT_CYC=16: 2 bytes on ch1, then silence -> oTimeout[1] pulses 16 cycles after
//   the last byte; next 4 bytes form a clean packet.

Source files
------------

// File: rtl/lcb_rx_collector.sv
// N-channel LCB answer collector: per-channel packet buffers drained round-robin as one byte stream.
// Define RX_TIMEOUT_EN to discard partial packets after TIMEOUT_CYC idle clocks.
module lcb_rx_collector #(
  parameter int NCH         = 5,
  parameter int PKT_BYTES   = 4,
  parameter int CHW         = 3,
  parameter int TIMEOUT_CYC = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*8-1:0] iData,
  input  logic [NCH-1:0]   iValid,
  input  logic             iReady,
  output logic [7:0]       oData,
  output logic [CHW-1:0]   oChan,
  output logic             oValid,
  output logic             oFirst,
  output logic             oLast,
  output logic [NCH-1:0]   oFull,
  output logic [NCH-1:0]   oOvf,
  output logic [NCH-1:0]   oTimeout
);
  localparam int AW = $clog2(PKT_BYTES);
  localparam logic [AW-1:0] LASTA = AW'(PKT_BYTES - 1);

  typedef enum logic [1:0] {FILL, READY, DRAIN} ch_st_e;
  typedef enum logic {IDLE, SEND} arb_st_e;

  ch_st_e         st_q [NCH];
  ch_st_e         st_d [NCH];
  logic [AW-1:0]  wr_q [NCH];
  logic [AW-1:0]  wr_d [NCH];
  logic [7:0]     mem_q [NCH][PKT_BYTES];
  logic [7:0]     mem_d [NCH][PKT_BYTES];
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] to_q, to_d;
  arb_st_e        arb_q, arb_d;
  logic [CHW-1:0] last_q, last_d;
  logic [CHW-1:0] chan_q, chan_d;
  logic [AW-1:0]  rd_q, rd_d, rd_n;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           first_q, first_d;
  logic           lastb_q, lastb_d;
  logic           found;
  logic [CHW-1:0] pick;
  int             idx;
  logic           hs;

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmr_q [NCH];
  logic [TW-1:0] tmr_d [NCH];
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  assign hs   = valid_q & iReady;
  assign rd_n = rd_q + 1'b1;

  // Scan starts just after the last served channel.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(last_q) + i) % NCH;
      if (!found && st_q[idx] == READY) begin
        found = 1'b1;
        pick  = CHW'(idx);
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    wr_d    = wr_q;
    mem_d   = mem_q;
    ovf_d   = ovf_q;
    to_d    = '0;
    arb_d   = arb_q;
    last_d  = last_q;
    chan_d  = chan_q;
    rd_d    = rd_q;
    data_d  = data_q;
    valid_d = valid_q;
    first_d = first_q;
    lastb_d = lastb_q;
`ifdef RX_TIMEOUT_EN
    tmr_d   = tmr_q;
`endif
    for (int c = 0; c < NCH; c++) begin
      if (iValid[c]) begin
        if (st_q[c] == FILL) begin
          mem_d[c][wr_q[c]] = iData[8*c +: 8];
          if (wr_q[c] == LASTA) begin
            st_d[c] = READY;
            wr_d[c] = '0;
          end else begin
            wr_d[c] = wr_q[c] + 1'b1;
          end
        end else begin
          ovf_d[c] = 1'b1;
        end
      end
`ifdef RX_TIMEOUT_EN
      if (st_q[c] == FILL && wr_q[c] != '0 && !iValid[c]) begin
        if (tmr_q[c] == TLAST) begin
          wr_d[c]  = '0;
          to_d[c]  = 1'b1;
          tmr_d[c] = '0;
        end else begin
          tmr_d[c] = tmr_q[c] + 1'b1;
        end
      end else begin
        tmr_d[c] = '0;
      end
`endif
    end
    unique case (arb_q)
      IDLE: begin
        if (found) begin
          st_d[pick] = DRAIN;
          arb_d      = SEND;
          last_d     = pick;
          chan_d     = pick;
          rd_d       = '0;
          data_d     = mem_q[pick][0];
          valid_d    = 1'b1;
          first_d    = 1'b1;
          lastb_d    = 1'b0;
        end
      end
      SEND: begin
        if (hs) begin
          if (rd_q == LASTA) begin
            st_d[chan_q] = FILL;
            arb_d        = IDLE;
            valid_d      = 1'b0;
            first_d      = 1'b0;
            lastb_d      = 1'b0;
          end else begin
            rd_d    = rd_n;
            data_d  = mem_q[chan_q][rd_n];
            first_d = 1'b0;
            lastb_d = (rd_n == LASTA);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= '{default: FILL};
      wr_q    <= '{default: '0};
      mem_q   <= '{default: '{default: '0}};
      ovf_q   <= '0;
      to_q    <= '0;
      arb_q   <= IDLE;
      last_q  <= CHW'(NCH - 1);
      chan_q  <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      lastb_q <= 1'b0;
`ifdef RX_TIMEOUT_EN
      tmr_q   <= '{default: '0};
`endif
    end else begin
      st_q    <= st_d;
      wr_q    <= wr_d;
      mem_q   <= mem_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
      arb_q   <= arb_d;
      last_q  <= last_d;
      chan_q  <= chan_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      first_q <= first_d;
      lastb_q <= lastb_d;
`ifdef RX_TIMEOUT_EN
      tmr_q   <= tmr_d;
`endif
    end
  end

  always_comb begin
    oFull = '0;
    for (int c = 0; c < NCH; c++) oFull[c] = (st_q[c] != FILL);
  end

  assign oData    = data_q;
  assign oChan    = chan_q;
  assign oValid   = valid_q;
  assign oFirst   = first_q;
  assign oLast    = lastb_q;
  assign oOvf     = ovf_q;
  assign oTimeout = to_q;
endmodule
